// File: rtl/coffee_pkg.sv
// Shared types and default timing constants for the coffee dispenser.
// States, default phase lengths and queue depth live here so the top,
// the phase timer user and the bench all agree on one definition.
package coffee_pkg;

  // Sequencer states; FAULT is only reachable when COFFEE_CUP_CHECK_EN is defined.
  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_CUP   = 3'd1,
    ST_HEAT  = 3'd2,
    ST_POUR  = 3'd3,
    ST_DONE  = 3'd4,
    ST_FAULT = 3'd5
  } state_t;

  // Default phase lengths in clock cycles.
  localparam int DEF_T_CUP    = 4;
  localparam int DEF_T_HEAT   = 16;
  localparam int DEF_T_POUR   = 32;

  // Default depth of the request queue (legal range 1..7, pending is 3 bits).
  localparam int DEF_PEND_MAX = 3;

  // Largest of three phase lengths; sizes the shared phase timer.
  function automatic int max3(input int a, input int b, input int c);
    int m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    return m;
  endfunction

endpackage

// File: rtl/phase_timer.sv
// Loadable down-counter with a zero flag.
// A load takes priority over counting; once at zero the counter holds there
// until the next load, so zero_o stays high in states that never reload it.
module phase_timer #(
  parameter int W = 6
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         load_i,
  input  logic [W-1:0] load_val_i,
  output logic         zero_o
);

  logic [W-1:0] count_q;
  logic [W-1:0] count_d;

  // Next count: reload on request, otherwise step down and stick at zero.
  always_comb begin
    count_d = count_q;
    if (load_i) begin
      count_d = load_val_i;
    end else if (count_q != '0) begin
      count_d = count_q - W'(1);
    end
  end

  // Counter register, cleared by the asynchronous reset.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign zero_o = (count_q == '0);

endmodule

// File: rtl/coffee_dispenser.sv
// Coffee dispenser sequencer: queues coffee requests and runs each one
// through CUP -> HEAT -> POUR -> DONE, with phase lengths set by parameters.
//
// Optional feature macro: COFFEE_CUP_CHECK_EN. When defined, losing the cup
// (cup_present low) during HEAT or POUR aborts the current coffee into FAULT
// until the cup is back; queued requests survive. When undefined, cup_present
// is ignored and fault is tied low.
//
// cafea has no backpressure: every cycle it is sampled high is one request,
// accepted if the queue has room, otherwise lost with a one-cycle drop_err.
//
// Actuator outputs, busy, done and fault are Moore outputs registered from the
// next state, so they change on the same edge as the state register.
module coffee_dispenser
  import coffee_pkg::*;
#(
  parameter int T_CUP    = DEF_T_CUP,
  parameter int T_HEAT   = DEF_T_HEAT,
  parameter int T_POUR   = DEF_T_POUR,
  parameter int PEND_MAX = DEF_PEND_MAX
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       cafea,
  input  logic       cup_present,
  output logic       cup_drop,
  output logic       heater_on,
  output logic       valve_open,
  output logic       busy,
  output logic       done,
  output logic [2:0] pending,
  output logic       drop_err,
  output logic       fault,
  output state_t     state_o
);

  localparam int T_MAX = max3(T_CUP, T_HEAT, T_POUR);
  localparam int TW    = $clog2(T_MAX + 1);
  localparam logic [2:0] PEND_LIM = 3'(PEND_MAX);

  state_t     state_q;
  state_t     state_d;
  logic [2:0] pending_q;
  logic [2:0] pending_d;
  logic       drop_err_q;
  logic       cup_drop_q;
  logic       heater_on_q;
  logic       valve_open_q;
  logic       busy_q;
  logic       done_q;

  logic       req_ok;
  logic       req_drop;
  logic       take;
  logic       tmr_load;
  logic [TW-1:0] tmr_val;
  logic       tmr_zero;
  logic       cup_lost;

  // Timer reload value for the state being entered: length minus one, so a
  // phase of N cycles sees the zero flag on its last cycle.
  function automatic logic [TW-1:0] load_for(input state_t s);
    case (s)
      ST_CUP:  return TW'(T_CUP - 1);
      ST_HEAT: return TW'(T_HEAT - 1);
      ST_POUR: return TW'(T_POUR - 1);
      default: return '0;
    endcase
  endfunction

`ifdef COFFEE_CUP_CHECK_EN
  assign cup_lost = ~cup_present;
`else
  logic unused_cup_present;
  assign unused_cup_present = cup_present;
  assign cup_lost = 1'b0;
`endif

  // Next-state selection; a lost cup outranks phase expiry in HEAT and POUR.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE: begin
        if (pending_q != 3'd0) state_d = ST_CUP;
      end
      ST_CUP: begin
        if (tmr_zero) state_d = ST_HEAT;
      end
      ST_HEAT: begin
        if (cup_lost)      state_d = ST_FAULT;
        else if (tmr_zero) state_d = ST_POUR;
      end
      ST_POUR: begin
        if (cup_lost)      state_d = ST_FAULT;
        else if (tmr_zero) state_d = ST_DONE;
      end
      ST_DONE: begin
        state_d = (pending_q != 3'd0) ? ST_CUP : ST_IDLE;
      end
      ST_FAULT: begin
`ifdef COFFEE_CUP_CHECK_EN
        if (cup_present) state_d = ST_IDLE;
`else
        state_d = ST_IDLE;
`endif
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Queue bookkeeping: accept or drop the incoming request against the
  // current count, and consume one request whenever a coffee is started.
  always_comb begin
    req_ok    = cafea && (pending_q < PEND_LIM);
    req_drop  = cafea && (pending_q >= PEND_LIM);
    take      = (state_d == ST_CUP) && (state_q != ST_CUP);
    pending_d = pending_q + {2'b00, req_ok} - {2'b00, take};
  end

  // The phase timer restarts on every state change.
  always_comb begin
    tmr_load = (state_d != state_q);
    tmr_val  = load_for(state_d);
  end

  phase_timer #(
    .W(TW)
  ) u_phase_timer (
    .clock      (clock),
    .reset      (reset),
    .load_i     (tmr_load),
    .load_val_i (tmr_val),
    .zero_o     (tmr_zero)
  );

  // Sequencer state, queue count and registered Moore outputs.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q      <= ST_IDLE;
      pending_q    <= 3'd0;
      drop_err_q   <= 1'b0;
      cup_drop_q   <= 1'b0;
      heater_on_q  <= 1'b0;
      valve_open_q <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      pending_q    <= pending_d;
      drop_err_q   <= req_drop;
      cup_drop_q   <= (state_d == ST_CUP);
      heater_on_q  <= (state_d == ST_HEAT);
      valve_open_q <= (state_d == ST_POUR);
      busy_q       <= (state_d != ST_IDLE);
      done_q       <= (state_d == ST_DONE);
    end
  end

`ifdef COFFEE_CUP_CHECK_EN
  logic fault_q;

  // Fault indicator, registered alongside the other Moore outputs.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      fault_q <= 1'b0;
    end else begin
      fault_q <= (state_d == ST_FAULT);
    end
  end

  assign fault = fault_q;
`else
  assign fault = 1'b0;
`endif

  assign cup_drop   = cup_drop_q;
  assign heater_on  = heater_on_q;
  assign valve_open = valve_open_q;
  assign busy       = busy_q;
  assign done       = done_q;
  assign pending    = pending_q;
  assign drop_err   = drop_err_q;
  assign state_o    = state_q;

endmodule

// File: tb/tb_coffee_dispenser.sv
// Bench for coffee_dispenser at default parameters. The reference model
// tracks a request count and the elapsed cycles of the coffee in progress,
// deriving the phase from elapsed time rather than from a state machine.
module tb_coffee_dispenser;
  import coffee_pkg::*;

  localparam int TC    = DEF_T_CUP;
  localparam int TH    = DEF_T_HEAT;
  localparam int TP    = DEF_T_POUR;
  localparam int PM    = DEF_PEND_MAX;
  localparam int TOTAL = TC + TH + TP;
`ifdef COFFEE_CUP_CHECK_EN
  localparam bit CHECK_EN = 1'b1;
`else
  localparam bit CHECK_EN = 1'b0;
`endif

  logic       clock;
  logic       reset;
  logic       cafea;
  logic       cup_present;
  logic       cup_drop;
  logic       heater_on;
  logic       valve_open;
  logic       busy;
  logic       done;
  logic [2:0] pending;
  logic       drop_err;
  logic       fault;
  state_t     state_o;
  logic [9:0] obs;

  int checks = 0;
  int errors = 0;

  coffee_dispenser dut (
    .clock       (clock),
    .reset       (reset),
    .cafea       (cafea),
    .cup_present (cup_present),
    .cup_drop    (cup_drop),
    .heater_on   (heater_on),
    .valve_open  (valve_open),
    .busy        (busy),
    .done        (done),
    .pending     (pending),
    .drop_err    (drop_err),
    .fault       (fault),
    .state_o     (state_o)
  );

  assign obs = {cup_drop, heater_on, valve_open, busy, done, pending, drop_err, fault};

  // ---------------- clock / reset ----------------
  initial clock = 1'b0;
  always #5 clock = ~clock;

  // ---------------- reference model ----------------
  int m_pend;
  bit m_active;
  int m_el;
  bit m_fault;
  bit m_drop;

  function automatic void model_reset();
    m_pend = 0; m_active = 0; m_el = 0; m_fault = 0; m_drop = 0;
  endfunction

  function automatic void model_step(input bit c, input bit p);
    bit acc;
    bit brewing;
    acc     = c && (m_pend < PM);
    m_drop  = c && (m_pend >= PM);
    brewing = m_active && (m_el >= TC) && (m_el < TOTAL);
    if (m_fault) begin
      if (p) m_fault = 0;
    end else if (m_active) begin
      if (CHECK_EN && brewing && !p) begin
        m_active = 0;
        m_fault  = 1;
      end else if (m_el == TOTAL) begin
        if (m_pend > 0) begin m_el = 0; m_pend--; end
        else m_active = 0;
      end else begin
        m_el++;
      end
    end else if (m_pend > 0) begin
      m_active = 1; m_el = 0; m_pend--;
    end
    if (acc) m_pend++;
  endfunction

  function automatic logic [9:0] model_out();
    bit cd, ht, vo, dn, bz;
    cd = m_active && (m_el < TC);
    ht = m_active && (m_el >= TC) && (m_el < TC + TH);
    vo = m_active && (m_el >= TC + TH) && (m_el < TOTAL);
    dn = m_active && (m_el == TOTAL);
    bz = m_active || m_fault;
    return {cd, ht, vo, bz, dn, 3'(m_pend), m_drop, m_fault};
  endfunction

  // ---------------- driver tasks ----------------
  // One clock edge: inputs are captured as the DUT sees them at the edge,
  // the model advances, and outputs are left settled 1 time unit later.
  task automatic tick();
    bit c, p;
    c = cafea;
    p = cup_present;
    @(posedge clock);
    if (reset) model_reset();
    else model_step(c, p);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1; cafea = 1'b0; cup_present = 1'b1;
    tick();
    tick();
    reset = 1'b0;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    reset = 1'b1; cafea = 1'b1; cup_present = 1'b1;
    #2;
    checks++;
    if (obs !== 10'd0 || state_o !== ST_IDLE) begin
      errors++;
      $display("FAIL reset_initial got %b state %0d want 0 state 0", obs, state_o);
    end
    tick();
    checks++;
    if (obs !== 10'd0) begin
      errors++;
      $display("FAIL reset_hold got %b want 0", obs);
    end
    cafea = 1'b0;
    reset = 1'b0;
  endtask

  // Single coffee against the fixed schedule: cup 2-5, heat 6-21, pour 22-53, done 54.
  task automatic test_single();
    logic [4:0] want;
    do_reset();
    for (int k = 1; k <= 58; k++) begin
      cafea = (k == 1);
      tick();
      want = {(k >= 2 && k <= 5), (k >= 6 && k <= 21), (k >= 22 && k <= 53),
              (k >= 2 && k <= 54), (k == 54)};
      checks++;
      if (obs[9:5] !== want) begin
        errors++;
        $display("FAIL single_sched edge %0d got %b want %b", k, obs[9:5], want);
      end
      checks++;
      if (obs !== model_out()) begin
        errors++;
        $display("FAIL single_model edge %0d got %b want %b", k, obs, model_out());
      end
    end
  endtask

  // Request arriving on the edge IDLE leaves: increment and decrement cancel.
  task automatic test_same_cycle();
    do_reset();
    for (int k = 1; k <= 60; k++) begin
      cafea = (k == 1 || k == 2);
      tick();
      if (k == 2) begin
        checks++;
        if (pending !== 3'd1 || cup_drop !== 1'b1) begin
          errors++;
          $display("FAIL same_cycle pending %0d cup %b want 1 1", pending, cup_drop);
        end
      end
      checks++;
      if (obs !== model_out()) begin
        errors++;
        $display("FAIL same_model edge %0d got %b want %b", k, obs, model_out());
      end
    end
  endtask

  // Four requests while busy: queue fills, one dropped, three run back-to-back.
  task automatic test_queue();
    int dones;
    int drops;
    dones = 0; drops = 0;
    do_reset();
    for (int k = 1; k <= 230; k++) begin
      cafea = (k == 1) || (k >= 11 && k <= 14);
      tick();
      if (done) dones++;
      if (drop_err) drops++;
      if (k == 13 || k == 14) begin
        checks++;
        if (pending !== 3'd3 || drop_err !== (k == 14)) begin
          errors++;
          $display("FAIL queue_fill edge %0d pending %0d drop %b want 3 %b", k, pending, drop_err, k == 14);
        end
      end
      if (k == 55) begin
        checks++;
        if (cup_drop !== 1'b1 || pending !== 3'd2) begin
          errors++;
          $display("FAIL queue_b2b cup %b pending %0d want 1 2", cup_drop, pending);
        end
      end
      checks++;
      if (obs !== model_out()) begin
        errors++;
        $display("FAIL queue_model edge %0d got %b want %b", k, obs, model_out());
      end
    end
    checks++;
    if (dones !== 4 || drops !== 1 || busy !== 1'b0) begin
      errors++;
      $display("FAIL queue_totals dones %0d drops %0d busy %b want 4 1 0", dones, drops, busy);
    end
  endtask

  // Cup removed at pour cycle 10 with one request queued.
  task automatic test_cup_presence();
    int dones;
    dones = 0;
    do_reset();
    for (int k = 1; k <= 200; k++) begin
      cafea = (k == 1 || k == 9);
      cup_present = !(k == 32 || (CHECK_EN && k == 33));
      tick();
      if (done) dones++;
      if (k == 32) begin
        checks++;
        if (fault !== CHECK_EN || valve_open !== !CHECK_EN || pending !== 3'd1) begin
          errors++;
          $display("FAIL cup_loss fault %b valve %b pending %0d want %b %b 1",
                   fault, valve_open, pending, CHECK_EN, !CHECK_EN);
        end
      end
      if (CHECK_EN && k == 34) begin
        checks++;
        if (busy !== 1'b0 || fault !== 1'b0 || pending !== 3'd1) begin
          errors++;
          $display("FAIL cup_back busy %b fault %b pending %0d want 0 0 1", busy, fault, pending);
        end
      end
      checks++;
      if (obs !== model_out()) begin
        errors++;
        $display("FAIL cup_model edge %0d got %b want %b", k, obs, model_out());
      end
    end
    checks++;
    if (dones !== (CHECK_EN ? 1 : 2)) begin
      errors++;
      $display("FAIL cup_dones got %0d want %0d", dones, CHECK_EN ? 1 : 2);
    end
    cup_present = 1'b1;
  endtask

  // Asynchronous reset in the middle of HEAT with two requests queued.
  task automatic test_reset_mid();
    do_reset();
    for (int k = 1; k <= 10; k++) begin
      cafea = (k == 1 || k == 7 || k == 8);
      tick();
    end
    cafea = 1'b0;
    checks++;
    if (heater_on !== 1'b1 || pending !== 3'd2) begin
      errors++;
      $display("FAIL mid_setup heater %b pending %0d want 1 2", heater_on, pending);
    end
    #2;
    reset = 1'b1;
    #1;
    model_reset();
    checks++;
    if (obs !== 10'd0 || state_o !== ST_IDLE) begin
      errors++;
      $display("FAIL mid_async got %b state %0d want 0 state 0", obs, state_o);
    end
    tick();
    reset = 1'b0;
    for (int k = 0; k < 4; k++) begin
      tick();
      checks++;
      if (obs !== model_out() || busy !== 1'b0) begin
        errors++;
        $display("FAIL mid_after cyc %0d got %b want %b", k, obs, model_out());
      end
    end
  endtask

  // Random request and cup-sensor traffic against the model.
  task automatic test_random();
    do_reset();
    for (int k = 0; k < 3000; k++) begin
      cafea       = ($urandom_range(0, 14) == 0);
      cup_present = ($urandom_range(0, 39) != 0);
      tick();
      checks++;
      if (obs !== model_out()) begin
        errors++;
        $display("FAIL random cyc %0d got %b want %b", k, obs, model_out());
      end
    end
    cafea = 1'b0;
    cup_present = 1'b1;
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    model_reset();
    test_reset();
    test_single();
    test_same_cycle();
    test_queue();
    test_cup_presence();
    test_reset_mid();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/coffee_dispenser.md
COFFEE_DISPENSER -- requirements
Module: coffee_dispenser

Interface
REQ-001 Parameter T_CUP, default 4, cycles cup_drop is held asserted.
REQ-002 Parameter T_HEAT, default 16, cycles heater_on is held asserted.
REQ-003 Parameter T_POUR, default 32, cycles valve_open is held asserted.
REQ-004 Parameter PEND_MAX, default 3, maximum queued coffee requests (1..7).
REQ-005 clock  input  1  clock; all state changes on rising edge.
REQ-006 reset  input  1  reset, asynchronous, active-high.
REQ-007 cafea  input  1  coffee request from coin FSM; each cycle sampled high is one request.
REQ-008 cup_present  input  1  cup sensor, high when a cup sits under the spout.
REQ-009 cup_drop  output  1  cup dispenser solenoid.
REQ-010 heater_on  output  1  water heater enable.
REQ-011 valve_open  output  1  pour valve enable.
REQ-012 busy  output  1  high in any state other than IDLE.
REQ-013 done  output  1  one-cycle pulse, coffee completed.
REQ-014 pending  output  3  queued request count.
REQ-015 drop_err  output  1  one-cycle pulse, request lost because the queue is full.
REQ-016 fault  output  1  high while in FAULT.

Function
REQ-017 States SHALL be IDLE, CUP, HEAT, POUR, DONE, FAULT; all outputs except pending and drop_err SHALL be Moore-decoded from state.
REQ-018 Decode: CUP→cup_drop; HEAT→heater_on; POUR→valve_open; DONE→done; FAULT→fault; busy = state≠IDLE.
REQ-019 cafea=1 with pending<PEND_MAX SHALL increment pending at the next edge.
REQ-020 cafea=1 with pending=PEND_MAX SHALL leave pending unchanged and pulse drop_err for one cycle at the next edge.
REQ-021 IDLE with pending>0 SHALL go to CUP at the next edge and decrement pending on that edge; a simultaneous increment SHALL leave pending unchanged.
REQ-022 Latency: cafea high before edge n in IDLE with empty queue gives cup_drop high after edge n+1.
REQ-023 CUP, HEAT and POUR SHALL each last exactly T_CUP, T_HEAT and T_POUR cycles, then advance CUP→HEAT→POUR→DONE.
REQ-024 DONE SHALL last one cycle, then go to CUP (pending decremented) if pending>0, else IDLE.
REQ-025 Requests arriving in any state SHALL be queued per REQ-019/020.
REQ-026 Phase timer SHALL be $clog2(max(T_CUP,T_HEAT,T_POUR)+1) bits, reloaded on every state entry, counting down to zero.

Reset
REQ-027 Reset SHALL force state=IDLE, pending=0, timer=0, drop_err=0; all outputs 0 while reset is high.
REQ-028 Reset mid-sequence SHALL abandon the coffee in progress and all queued requests.

Configuration
REQ-029 With COFFEE_CUP_CHECK_EN defined: cup_present=0 sampled in HEAT or POUR SHALL go to FAULT at the next edge and drop the current coffee; FAULT SHALL return to IDLE on the first edge with cup_present=1; queued requests SHALL be kept.
REQ-030 Without COFFEE_CUP_CHECK_EN: cup_present SHALL be ignored, FAULT SHALL be unreachable, and fault SHALL be constant 0.

Structure
REQ-031 Package coffee_pkg SHALL hold the state enum typedef and the default T_CUP/T_HEAT/T_POUR/PEND_MAX constants.
REQ-032 Sub-module phase_timer SHALL be a loadable down-counter with a zero flag, instantiated once.

Verification
REQ-033 Defaults, cup_present=1, cafea pulsed before edge 1 → cup_drop after edges 2-5, heater_on 6-21, valve_open 22-53, done at 54, IDLE at 55.
REQ-034 Four cafea pulses while busy (pending=0 at start) → pending reaches 3, fourth pulse gives one drop_err, three more full sequences run back-to-back through DONE→CUP.
REQ-035 cafea in the same cycle that IDLE leaves with pending=1 → pending stays 1.
REQ-036 COFFEE_CUP_CHECK_EN, cup_present dropped at POUR cycle 10 → FAULT next edge, valve_open 0, no done; cup_present restored → IDLE, queue intact.
REQ-037 Reset asserted mid-HEAT with pending=2 → all outputs 0 immediately, pending=0, IDLE after release.
